// File: rtl/pcpi_div_pkg.sv
// Shared types, instruction-field constants and the M-extension divide decode.
// Imported by the PCPI divider top and its iteration step unit.
package pcpi_div_pkg;

  typedef enum logic [1:0] {
    DIV  = 2'b00,
    DIVU = 2'b01,
    REM  = 2'b10,
    REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_e;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic div_decode(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_OP) && (insn[31:25] == FUNCT7_MULDIV) && insn[14];
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// Combinational STEPS-stage restoring divide slice: shift in dividend bits MSB first, subtract when possible.
// Zero latency, no flow control; the caller registers the remainder and quotient bits.
module div_iter_step #(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic [XLEN:0]    rem,
  input  logic [STEPS-1:0] bits,
  input  logic [XLEN-1:0]  divisor,
  output logic [XLEN:0]    rem_nxt,
  output logic [STEPS-1:0] quo
);

  logic [XLEN:0] acc;

  // remainder stays below the divisor between stages, so the shift never loses a set bit
  always_comb begin
    acc = rem;
    quo = '0;
    for (int s = STEPS - 1; s >= 0; s--) begin
      acc = {acc[XLEN-1:0], bits[s]};
      if (acc >= {1'b0, divisor}) begin
        acc    = acc - {1'b0, divisor};
        quo[s] = 1'b1;
      end
    end
    rem_nxt = acc;
  end

endmodule

// File: rtl/pcpi_div_param.sv
// PCPI DIV/DIVU/REM/REMU co-processor, XLEN/STEPS cycles + 1 to ready; dropping pcpi_valid mid-op aborts it.
// PCPI_DIV_FAST_PATH_EN: divide-by-zero and signed overflow complete in one cycle.
module pcpi_div_param
  import pcpi_div_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int STEPS = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_wr,
  output logic [XLEN-1:0] pcpi_rd,
  output logic            pcpi_wait,
  output logic            pcpi_ready
);

  localparam int K  = XLEN / STEPS;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  div_state_e    state_q;
  div_op_e       op_q;
  logic          done_q;
  logic          neg_q;
  logic          neg_r;
  logic [CW-1:0] cnt_q;
  logic [XLEN-1:0] dvd_q;
  logic [XLEN-1:0] dsr_q;
  logic [XLEN:0]   rem_q;

  div_op_e         op_in;
  logic            in_signed;
  logic            in_rem;
  logic            start;
  logic [XLEN-1:0] rs1_abs;
  logic [XLEN-1:0] rs2_abs;

  assign op_in     = div_op_e'(pcpi_insn[13:12]);
  assign in_signed = (op_in == DIV) || (op_in == REM);
  assign in_rem    = (op_in == REM) || (op_in == REMU);
  assign start     = pcpi_valid && div_decode(pcpi_insn) && !done_q;
  assign rs1_abs   = (in_signed && pcpi_rs1[XLEN-1]) ? -pcpi_rs1 : pcpi_rs1;
  assign rs2_abs   = (in_signed && pcpi_rs2[XLEN-1]) ? -pcpi_rs2 : pcpi_rs2;

  logic [XLEN:0]    rem_nxt;
  logic [STEPS-1:0] q_bits;
  logic [XLEN-1:0]  quo_nxt;
  logic [XLEN-1:0]  res_mag;
  logic             rem_op;
  logic             res_neg;

  div_iter_step #(
    .XLEN (XLEN),
    .STEPS(STEPS)
  ) u_step (
    .rem    (rem_q),
    .bits   (dvd_q[XLEN-1 -: STEPS]),
    .divisor(dsr_q),
    .rem_nxt(rem_nxt),
    .quo    (q_bits)
  );

  // dividend bits leave at the top while quotient bits enter at the bottom
  assign quo_nxt = {dvd_q[XLEN-STEPS-1:0], q_bits};
  assign rem_op  = (op_q == REM) || (op_q == REMU);
  assign res_mag = rem_op ? rem_nxt[XLEN-1:0] : quo_nxt;
  assign res_neg = rem_op ? neg_r : neg_q;

`ifdef PCPI_DIV_FAST_PATH_EN
  logic            div0;
  logic            ovf;
  logic [XLEN-1:0] fast_res;

  assign div0 = (pcpi_rs2 == '0);
  assign ovf  = in_signed && (pcpi_rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (pcpi_rs2 == '1);

  always_comb begin
    fast_res = '0;
    if (div0)
      fast_res = in_rem ? pcpi_rs1 : '1;
    else if (!in_rem)
      fast_res = pcpi_rs1;
  end
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      op_q       <= DIV;
      done_q     <= 1'b0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      cnt_q      <= '0;
      dvd_q      <= '0;
      dsr_q      <= '0;
      rem_q      <= '0;
      pcpi_wr    <= 1'b0;
      pcpi_rd    <= '0;
      pcpi_wait  <= 1'b0;
      pcpi_ready <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wr    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op_in;
            dvd_q <= rs1_abs;
            dsr_q <= rs2_abs;
            rem_q <= '0;
            cnt_q <= '0;
            neg_q <= in_signed && (pcpi_rs1[XLEN-1] ^ pcpi_rs2[XLEN-1]) && (pcpi_rs2 != '0);
            neg_r <= (op_in == REM) && pcpi_rs1[XLEN-1];
`ifdef PCPI_DIV_FAST_PATH_EN
            if (div0 || ovf) begin
              state_q    <= DONE;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              pcpi_rd    <= fast_res;
            end else begin
              state_q   <= CALC;
              pcpi_wait <= 1'b1;
            end
`else
            state_q   <= CALC;
            pcpi_wait <= 1'b1;
`endif
          end
        end
        CALC: begin
          if (!pcpi_valid) begin
            state_q   <= IDLE;
            pcpi_wait <= 1'b0;
          end else begin
            rem_q <= rem_nxt;
            dvd_q <= quo_nxt;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CW'(K - 1)) begin
              state_q    <= DONE;
              pcpi_wait  <= 1'b0;
              pcpi_ready <= 1'b1;
              pcpi_wr    <= 1'b1;
              pcpi_rd    <= res_neg ? -res_mag : res_mag;
            end
          end
        end
        DONE: begin
          // blocks the core's one extra cycle of pcpi_valid after ready
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pcpi_div_param.md
# pcpi_div_param

Parametrised iterative divider co-processor on the PicoRV32 PCPI port, executing RV M-extension DIV, DIVU, REM and REMU. It generalises the fixed 32-bit, one-bit-per-cycle divider in width (XLEN) and radix (STEPS bits retired per cycle). It implements full RISC-V divide-by-zero and signed-overflow semantics in hardware, so the bench needs no operand constraints. It sits beside the core in picosoc, in parallel with the PCPI multiplier.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- STEPS, 1: quotient bits per iteration cycle; 1, 2 or 4; must divide XLEN. K = XLEN/STEPS.
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- pcpi_valid  in  1  core requests a co-processor op; held until pcpi_ready.
- pcpi_insn  in  32  instruction word.
- pcpi_rs1  in  XLEN  dividend.
- pcpi_rs2  in  XLEN  divisor.
- pcpi_wr  out  1  result write-back strobe; only with pcpi_ready.
- pcpi_rd  out  XLEN  result.
- pcpi_wait  out  1  op accepted and in progress.
- pcpi_ready  out  1  one-cycle completion pulse.

## Operation
- Decode: opcode 7'b0110011, funct7 7'b0000001, funct3[2]=1. funct3[1:0] selects DIV=00, DIVU=01, REM=10, REMU=11. Non-matching insn: block stays silent.
- States are IDLE, CALC and DONE; there is also a `done_q` flag.
- IDLE→CALC: pcpi_valid & decode match & !done_q. The block latches op, |rs1| and |rs2| (magnitudes for signed ops, raw for unsigned), neg_q and neg_r.
  - neg_q = signed & rs1[MSB]^rs2[MSB] & rs2≠0.
  - neg_r = signed rem & rs1[MSB].
- CALC: restoring division, STEPS quotient bits per cycle via the step unit. Partial remainder is XLEN+1 bits. An iteration counter runs 0..K-1; after iteration K-1 the block goes to DONE.
- DONE: one cycle, then IDLE.
  - pcpi_rd = quotient or remainder, negated if neg_q or neg_r.
  - pcpi_ready=pcpi_wr=1 for that cycle.
  - done_q is set for one cycle so that the still-high valid in the following cycle does not restart an op.
- Divide by zero: DIV/DIVU result is all-ones. REM/REMU result is rs1. Negation is suppressed via neg_q.
- Signed overflow (rs1 = most-negative, rs2 = -1): DIV result is rs1, REM result is 0. These fall out of the magnitude path and need no special case.
- pcpi_valid dropping during CALC: the op is aborted, the FSM returns to IDLE next cycle, and no pcpi_ready is issued.
- resetn low at any time: FSM to IDLE, all outputs cleared immediately.

## Timing
- Reset values: pcpi_wr=0, pcpi_rd=0, pcpi_wait=0, pcpi_ready=0, state IDLE, done_q=0.
- T0: valid and match sampled.
- T1..TK: CALC, with pcpi_wait=1.
- TK+1: DONE, with pcpi_ready=pcpi_wr=1, pcpi_wait=0 and pcpi_rd valid.
- Latency from accept to ready is K+1 cycles.
- pcpi_rd holds its value until the next DONE.
- The earliest next accept is TK+3, because done_q blocks TK+2.
- pcpi_wait is registered and is never high in the same cycle as pcpi_ready.

## Configuration
- PCPI_DIV_FAST_PATH_EN defined: when rs2==0 or signed overflow is detected at accept, the FSM goes IDLE→DONE directly. Ready is at T1 (latency 1), pcpi_wait never rises, and the result is as specified above.
- PCPI_DIV_FAST_PATH_EN undefined: all ops take K+1 cycles. Results are identical in both builds.

## Structure
- Package pcpi_div_pkg holds:
  - the div_op_e enum (DIV, DIVU, REM, REMU);
  - the div_state_e enum (IDLE, CALC, DONE);
  - the OPCODE_OP and FUNCT7_MULDIV constants;
  - the decode function.
- Sub-module div_iter_step is combinational and performs STEPS restoring-subtract stages. Inputs are partial remainder, dividend bits and divisor. Outputs are next remainder and STEPS quotient bits.
- The top holds the FSM, counter, operand and sign registers, and output registers.

## Test plan
- XLEN=32, STEPS=1: DIVU 100/7 → pcpi_rd=14, pcpi_ready at T33, pcpi_wait high T1..T32.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; REMU 0xFFFFFFF9/2 → 1.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- DIV 5/0 → 0xFFFFFFFF; REM -5/0 → 0xFFFFFFFB.
  - With PCPI_DIV_FAST_PATH_EN: ready at T1.
  - Without: ready at T33.
- STEPS=4: DIVU 1000/3 → 333, ready at T9. Valid dropped at T4 → no ready, FSM back in IDLE at T5. resetn pulsed at T3 → all outputs 0.
- Back-to-back: valid held one cycle past ready → no restart; a new valid at TK+3 is accepted.
